// File: rtl/counter_pkg.sv
// Shared constants and helpers for the counter family.
package counter_pkg;

  // Direction encoding for the up input
  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Values for the SATURATE parameter
  localparam int MODE_WRAP = 32'sd0;
  localparam int MODE_SAT  = 32'sd1;

  // Width of the prescaler counter: clog2(prescale), never below one bit
  function automatic int psc_width(input int prescale);
    if (prescale <= 32'sd2) begin
      return 32'sd1;
    end else begin
      return $clog2(prescale);
    end
  endfunction

endpackage

// File: rtl/updown_mod_counter_tick_prescaler.sv
// Enable prescaler: emits one tick every PRESCALE enabled cycles.
module tick_prescaler
  import counter_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic restart,
  output logic tick
);

  generate
    if (PRESCALE == 32'sd1) begin : g_direct
      // Every enabled cycle is a step; no state needed.
      logic unused_s;
      assign unused_s = &{1'b0, clk, rst, restart};
      assign tick     = en;
    end else begin : g_count
      localparam int PW = psc_width(PRESCALE);
      localparam logic [PW-1:0] LAST = PW'(PRESCALE - 32'sd1);
      localparam logic [PW-1:0] ONE  = PW'(32'sd1);

      logic [PW-1:0] psc_r;

      // Phase counter: restarts on clr/load, advances only on enabled cycles
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          psc_r <= '0;
        end else if (restart) begin
          psc_r <= '0;
        end else if (en) begin
          if (psc_r == LAST) begin
            psc_r <= '0;
          end else begin
            psc_r <= psc_r + ONE;
          end
        end
      end

      assign tick = en && (psc_r == LAST);
    end
  endgenerate

endmodule

// File: rtl/updown_mod_counter.sv
// Parametrised up/down modulo counter with load, clear, prescaler,
// wrap/saturate mode and terminal-count / wrap / sticky-overflow flags.
module updown_mod_counter
  import counter_pkg::*;
#(
  parameter int              WIDTH    = 8,
  parameter longint unsigned MAX      = (64'd1 << WIDTH) - 64'd1,
  parameter int              PRESCALE = 1,
  parameter int              SATURATE = MODE_WRAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             ovf
);

  // Parameter legality checks, evaluated at elaboration
  generate
    if (WIDTH < 32'sd2 || WIDTH > 32'sd32) begin : g_bad_width
      $error("updown_mod_counter: WIDTH must be 2..32");
    end
    if (MAX < 64'd1 || MAX > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_max
      $error("updown_mod_counter: MAX must be 1..2**WIDTH-1");
    end
    if (PRESCALE < 32'sd1 || PRESCALE > 32'sd65535) begin : g_bad_psc
      $error("updown_mod_counter: PRESCALE must be 1..65535");
    end
    if (SATURATE != MODE_WRAP && SATURATE != MODE_SAT) begin : g_bad_sat
      $error("updown_mod_counter: SATURATE must be 0 or 1");
    end
  endgenerate

  localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] ZERO_V = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_V  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_r;
  logic             wrap_r;
  logic             ovf_r;
  logic             tick_s;
  logic             restart_s;
  logic [WIDTH-1:0] step_val_s;
  logic             hit_s;
  logic [WIDTH-1:0] load_clamp_s;

  // clr and load both realign the prescaler phase
  assign restart_s = clr | load;

  tick_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_psc (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .restart (restart_s),
    .tick    (tick_s)
  );

  // Next value for a step, never leaving 0..MAX; flags a limit hit
  always_comb begin
    step_val_s = count_r;
    hit_s      = 1'b0;
    if (up == DIR_UP) begin
      if (count_r == MAX_V) begin
        hit_s = 1'b1;
        if (SATURATE == MODE_SAT) begin
          step_val_s = MAX_V;
        end else begin
          step_val_s = ZERO_V;
        end
      end else begin
        step_val_s = count_r + ONE_V;
      end
    end else begin
      if (count_r == ZERO_V) begin
        hit_s = 1'b1;
        if (SATURATE == MODE_SAT) begin
          step_val_s = ZERO_V;
        end else begin
          step_val_s = MAX_V;
        end
      end else begin
        step_val_s = count_r - ONE_V;
      end
    end
  end

  // Load value clamped into range
  always_comb begin
    if (load_val > MAX_V) begin
      load_clamp_s = MAX_V;
    end else begin
      load_clamp_s = load_val;
    end
  end

  // Count and flag registers; priority clr > load > step
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= ZERO_V;
      wrap_r  <= 1'b0;
      ovf_r   <= 1'b0;
    end else if (clr) begin
      count_r <= ZERO_V;
      wrap_r  <= 1'b0;
      ovf_r   <= 1'b0;
    end else if (load) begin
      count_r <= load_clamp_s;
      wrap_r  <= 1'b0;
    end else if (tick_s) begin
      count_r <= step_val_s;
      wrap_r  <= hit_s;
      ovf_r   <= ovf_r | hit_s;
    end else begin
      wrap_r  <= 1'b0;
    end
  end

  assign count = count_r;
  assign wrap  = wrap_r;
  assign ovf   = ovf_r;
  assign tc    = (up == DIR_UP) ? (count_r == MAX_V) : (count_r == ZERO_V);

endmodule

// File: doc/updown_mod_counter.md
# updown_mod_counter

Parametrised up/down modulo counter; the next generation of the team's 2-bit enable/reset counter. Adds configurable width and modulus, direction control, parallel load, synchronous clear, an enable prescaler, wrap-or-saturate mode, and terminal-count, wrap and sticky-overflow flags. It serves as the general timing and event counter for sequencing logic built on the team's flip-flop primitives.

## Interface
- WIDTH, 8: counter width in bits (2..32)
- MAX, 2**WIDTH-1: terminal value; count range is 0..MAX (1 <= MAX <= 2**WIDTH-1)
- PRESCALE, 1: number of enabled cycles per count step (1..65535; 1 = step every enabled cycle)
- SATURATE, 0: 0 = wrap at limits, 1 = hold at limits
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- en  in  1  count enable; gates the prescaler
- up  in  1  direction: 1 = increment, 0 = decrement
- clr  in  1  synchronous clear
- load  in  1  synchronous parallel load
- load_val  in  WIDTH  value for load
- count  out  WIDTH  current count, registered
- tc  out  1  terminal count, combinational: (up && count==MAX) || (!up && count==0)
- wrap  out  1  one-cycle pulse, registered: a step hit a limit
- ovf  out  1  sticky: set by any limit hit, cleared only by rst or clr

## Operation
- Priority per rising edge: rst (async) > clr > load > step.
- rst asserted: count=0, wrap=0, ovf=0, prescaler=0, immediately and independent of clk. Outputs hold these values while rst is high.
- clr: count=0, prescaler=0, ovf=0, wrap=0.
- load: count=min(load_val, MAX), prescaler=0, wrap=0. ovf is unchanged.
- Prescaler: a counter psc runs 0..PRESCALE-1. It advances only on cycles with en=1 that have no clr and no load. tick = en && psc==PRESCALE-1. On tick, psc returns to 0. With en=0, psc holds.
- Step, on tick:
  - up=1, count<MAX: count+1.
  - up=1, count==MAX: count=0 if SATURATE=0, else count holds at MAX. In both cases wrap=1 next cycle and ovf=1.
  - up=0, count>0: count-1.
  - up=0, count==0: count=MAX if SATURATE=0, else count holds at 0. In both cases wrap=1 and ovf=1.
- wrap is 0 on every edge that does not take a limit-hitting step. It therefore never stays high for more than one cycle per limit hit. Back-to-back hits in saturate mode keep it high on each tick.
- Direction may change on any cycle. The step uses the value of up sampled on the tick edge.
- Arithmetic is unsigned and WIDTH bits wide. No intermediate value exceeds MAX. A non-power-of-2 MAX must never pass through values above MAX.

## Timing
- Latency: count, wrap and ovf update on the edge that samples tick, clr or load. They are visible in the following cycle.
- wrap is asserted in the same cycle as the post-limit count value.
- tc follows count and up combinationally, with no register stage.
- PRESCALE=1 gives one step per enabled clock. PRESCALE=N gives one step per N enabled clocks, which need not be consecutive.
- Reset mid-operation clears all state asynchronously. The first step after deassertion needs PRESCALE enabled cycles.
- clr and load together: clr wins.
- load and en together: load wins and the prescaler restarts.

## Structure
- Shared package counter_pkg holds:
  - DIR_UP=1'b1 and DIR_DOWN=1'b0
  - MODE_WRAP=0 and MODE_SAT=1 (the values for SATURATE)
  - a function computing the prescaler width, clog2(PRESCALE) with a minimum of 1
- One sub-module, tick_prescaler:
  - parameter PRESCALE
  - ports clk, rst, en, restart, tick
  - with PRESCALE=1, tick=en directly and it contains no register.
- Top level holds the count register, the limit/step logic, the flags and the parameter legality checks.

## Test plan
- WIDTH=4, MAX=9, wrap mode, up: en=1 for 12 cycles from reset. count must go 0..9, 0, 1. wrap pulses for one cycle with count=0. ovf=1 from then on. tc=1 while count=9.
- WIDTH=4, MAX=9, down, SATURATE=1: load_val=2 then en=1 for 5 cycles. count must go 2, 1, 0, 0, 0. wrap=1 on each hold at 0. count never shows 9.
- PRESCALE=3, up, en toggled 1,1,0,1,1,1,1: count increments only after the 3rd and 6th enabled cycles.
- Priority: load_val=15 with MAX=9 gives count=9. clr and load together give count=0 and ovf=0. load with en high restarts the prescaler.
- Async reset: assert rst between edges at count=7 with ovf=1. count, wrap and ovf must go to 0 before the next edge. After release, the first increment occurs after PRESCALE enabled cycles.
- WIDTH=8 defaults, direction flip at count=255 up then down: the wrap to 0 happens, the next step with up=0 gives count=255, and tc tracks the up changes combinationally.
